// File: rtl/d7s_scan_counter.sv
// d7s_scan_counter: prescaled up/down counter with load and wrap at MAX_COUNT.
// The count is converted to BCD by a sequential shift-add-3 converter, and the
// result drives a multiplexed DIGITS-wide 7-segment display.
//
// Optional feature: define D7S_BLANK_EN for leading-zero blanking. When it is
// undefined, every digit is shown, leading zeros included.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-low reset
//   en         1 = prescaler runs, 0 = prescaler and count hold
//   up         1 = count up, 0 = count down
//   load       1-cycle pulse; loads min(load_val, MAX_COUNT) and clears prescaler
//   load_val   value to load (CNT_W bits)
//   count      current binary count (CNT_W bits)
//   transistor one-hot digit enable, active high, bit 0 = units
//   d7sp       segments {g,f,e,d,c,b,a}, active high
module d7s_scan_counter #(
    parameter int unsigned DIGITS    = 4,
    parameter int unsigned CNT_W     = 14,
    parameter int unsigned MAX_COUNT = 9999,
    parameter int unsigned TICK_DIV  = 50000000,
    parameter int unsigned SCAN_DIV  = 50000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              up,
    input  logic              load,
    input  logic [CNT_W-1:0]  load_val,
    output logic [CNT_W-1:0]  count,
    output logic [DIGITS-1:0] transistor,
    output logic [6:0]        d7sp
);

    function automatic longint unsigned pow10_f(input int unsigned n);
        longint unsigned r;
        r = 64'd1;
        for (int unsigned k = 0; k < n; k++) r = r * 64'd10;
        return r;
    endfunction

    localparam int unsigned     BCD_W     = 4 * DIGITS;
    localparam int unsigned     PRE_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned     SCN_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned     IDX_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned     BIT_W     = $clog2(CNT_W + 1);
    localparam longint unsigned DEC_LIMIT = pow10_f(DIGITS);
    localparam longint unsigned BIN_LIMIT = 64'd1 << CNT_W;
    localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_COUNT);

    // Elaboration-time parameter sanity checks
    if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
        $error("d7s_scan_counter: DIGITS must be 1..8");
    end
    if (64'(MAX_COUNT) >= DEC_LIMIT || 64'(MAX_COUNT) >= BIN_LIMIT) begin : g_bad_max
        $error("d7s_scan_counter: MAX_COUNT does not fit DIGITS or CNT_W");
    end
    if (CNT_W < 2 || TICK_DIV <= CNT_W + 2) begin : g_bad_tick
        $error("d7s_scan_counter: need CNT_W >= 2 and TICK_DIV > CNT_W+2");
    end

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [PRE_W-1:0] pre_cnt;
    logic             tick_c;
    logic [1:0]       state, state_nxt;
    logic             first;
    logic [CNT_W-1:0] snap, shreg;
    logic [BCD_W-1:0] bcd, bcd_adj, disp;
    logic [BIT_W-1:0] bit_cnt;
    logic [SCN_W-1:0] scan_cnt;
    logic [IDX_W-1:0] digit_idx;
    logic [3:0]       nib;
    logic             blank;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    assign tick_c = en && (pre_cnt == PRE_W'(TICK_DIV - 1));

    // Prescaler and counter; load beats a coincident tick
    always_ff @(posedge clk) begin
        if (!rst) begin
            pre_cnt <= '0;
            count   <= '0;
        end else if (load) begin
            pre_cnt <= '0;
            count   <= (load_val > MAX_C) ? MAX_C : load_val;
        end else if (en) begin
            pre_cnt <= tick_c ? '0 : pre_cnt + PRE_W'(1);
            if (tick_c) begin
                if (up) count <= (count == MAX_C) ? '0 : count + CNT_W'(1);
                else    count <= (count == '0) ? MAX_C : count - CNT_W'(1);
            end
        end
    end

    // Converter state register
    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    // Converter next state; the bit counter marks the last of CNT_W shifts
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (first || count != snap) state_nxt = S_SHIFT;
            S_SHIFT: if (bit_cnt == BIT_W'(CNT_W - 1)) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Add 3 to every nibble >= 5 ahead of the shift
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    // Converter datapath
    always_ff @(posedge clk) begin
        if (!rst) begin
            first   <= 1'b1;
            snap    <= '0;
            shreg   <= '0;
            bcd     <= '0;
            bit_cnt <= '0;
            disp    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (state_nxt == S_SHIFT) begin
                        first   <= 1'b0;
                        snap    <= count;
                        shreg   <= count;
                        bcd     <= '0;
                        bit_cnt <= '0;
                    end
                end
                S_SHIFT: begin
                    bcd     <= {bcd_adj[BCD_W-2:0], shreg[CNT_W-1]};
                    shreg   <= {shreg[CNT_W-2:0], 1'b0};
                    bit_cnt <= bit_cnt + BIT_W'(1);
                end
                S_DONE:  disp <= bcd;
                default: ;
            endcase
        end
    end

    // Select the scanned nibble and decide whether it is a leading zero
    always_comb begin
`ifdef D7S_BLANK_EN
        logic upper_zero;
        upper_zero = 1'b1;
`endif
        nib   = '0;
        blank = 1'b0;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
`ifdef D7S_BLANK_EN
            upper_zero = upper_zero && (disp[4*i +: 4] == 4'd0);
`endif
            if (digit_idx == IDX_W'(i)) begin
                nib = disp[4*i +: 4];
`ifdef D7S_BLANK_EN
                blank = upper_zero && (i != 0);
`endif
            end
        end
    end

    // Scan timing; transistor and d7sp share one register edge
    always_ff @(posedge clk) begin
        if (!rst) begin
            scan_cnt   <= '0;
            digit_idx  <= '0;
            transistor <= DIGITS'(1);
            d7sp       <= 7'h3F;
        end else begin
            if (scan_cnt == SCN_W'(SCAN_DIV - 1)) begin
                scan_cnt  <= '0;
                digit_idx <= (digit_idx == IDX_W'(DIGITS - 1)) ? '0 : digit_idx + IDX_W'(1);
            end else begin
                scan_cnt <= scan_cnt + SCN_W'(1);
            end
            transistor <= DIGITS'(1) << digit_idx;
            d7sp       <= blank ? 7'h00 : seg7(nib);
        end
    end

endmodule

// File: tb/tb_d7s_scan_counter.sv
// Self-checking bench for d7s_scan_counter. A cycle-level behavioural model
// built from integer arithmetic checks count, transistor and d7sp every cycle.
// Directed scenarios add fixed expectations on top of that model.
module tb_d7s_scan_counter;

    localparam int DIGITS    = 3;
    localparam int CNT_W     = 10;
    localparam int MAX_COUNT = 999;
    localparam int TICK_DIV  = 16;
    localparam int SCAN_DIV  = 4;

    logic              clk = 1'b0;
    logic              rst, en, up, load;
    logic [CNT_W-1:0]  load_val;
    logic [CNT_W-1:0]  count;
    logic [DIGITS-1:0] transistor;
    logic [6:0]        d7sp;

    int n_cmp = 0;
    int n_bad = 0;

    logic [6:0] seg_tab [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                  7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

`ifdef D7S_BLANK_EN
    localparam logic [6:0] LEAD = 7'h00;
`else
    localparam logic [6:0] LEAD = 7'h3F;
`endif

    // Model state: values as integers, display value kept in decimal
    int m_cnt, m_pre, m_scan, m_idx, m_disp, m_snap, m_remain, m_tr, m_seg;
    bit m_first;

    always #5 clk = ~clk;

    d7s_scan_counter #(
        .DIGITS(DIGITS), .CNT_W(CNT_W), .MAX_COUNT(MAX_COUNT),
        .TICK_DIV(TICK_DIV), .SCAN_DIV(SCAN_DIV)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
        .load_val(load_val), .count(count), .transistor(transistor), .d7sp(d7sp)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int pow10(input int n);
        int r = 1;
        for (int k = 0; k < n; k++) r = r * 10;
        return r;
    endfunction

    // One clock edge of the reference behaviour, using inputs seen at the edge
    task automatic model_edge();
        int d;
        if (!rst) begin
            m_cnt = 0; m_pre = 0; m_scan = 0; m_idx = 0; m_disp = 0;
            m_snap = 0; m_remain = 0; m_first = 1'b1; m_tr = 1; m_seg = 'h3F;
        end else begin
            // outputs follow the digit index and display value held before this edge
            d     = (m_disp / pow10(m_idx)) % 10;
            m_tr  = 1 << m_idx;
            m_seg = int'(seg_tab[d]);
`ifdef D7S_BLANK_EN
            if (m_idx != 0 && m_disp < pow10(m_idx)) m_seg = 0;
`endif
            // conversion: display takes the snapshot CNT_W+1 edges after capture
            if (m_remain == 0) begin
                if (m_first || m_cnt != m_snap) begin
                    m_snap = m_cnt; m_first = 1'b0; m_remain = CNT_W + 1;
                end
            end else begin
                if (m_remain == 1) m_disp = m_snap;
                m_remain--;
            end
            if (m_scan == SCAN_DIV - 1) begin
                m_scan = 0; m_idx = (m_idx + 1) % DIGITS;
            end else begin
                m_scan++;
            end
            if (load) begin
                m_cnt = (int'(load_val) > MAX_COUNT) ? MAX_COUNT : int'(load_val);
                m_pre = 0;
            end else if (en) begin
                if (m_pre == TICK_DIV - 1) begin
                    m_pre = 0;
                    if (up) m_cnt = (m_cnt == MAX_COUNT) ? 0 : m_cnt + 1;
                    else    m_cnt = (m_cnt == 0) ? MAX_COUNT : m_cnt - 1;
                end else begin
                    m_pre++;
                end
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("count", 32'(count), 32'(m_cnt));
        check("transistor", 32'(transistor), 32'(m_tr));
        check("d7sp", 32'(d7sp), 32'(m_seg));
    endtask

    task automatic pulse_load(input int v);
        load_val = CNT_W'(v);
        load = 1'b1;
        cyc();
        load = 1'b0;
    endtask

    task automatic see_digit(input int i, input logic [6:0] exp, input string tag);
        for (int k = 0; k < SCAN_DIV * DIGITS + 2 && transistor != DIGITS'(1 << i); k++) cyc();
        check({tag, "_sel"}, 32'(transistor), 32'(1 << i));
        check(tag, 32'(d7sp), 32'(exp));
    endtask

    task automatic wait_count_change(input string tag, input int exp);
        logic [CNT_W-1:0] old;
        old = count;
        for (int k = 0; k < TICK_DIV + 2 && count == old; k++) cyc();
        check(tag, 32'(count), 32'(exp));
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; load_val = '0;
        m_cnt = 0; m_pre = 0; m_scan = 0; m_idx = 0; m_disp = 0;
        m_snap = 0; m_remain = 0; m_first = 1'b1; m_tr = 1; m_seg = 'h3F;

        // Reset values, then the scan sequence after release
        cyc(); cyc();
        check("rst_count", 32'(count), 32'd0);
        check("rst_tr", 32'(transistor), 32'b001);
        check("rst_seg", 32'(d7sp), 32'h3F);
        rst = 1'b1;
        repeat (4 * SCAN_DIV) cyc();

        // Up count: five ticks
        en = 1'b1; up = 1'b1;
        repeat (5 * TICK_DIV) cyc();
        check("up5", 32'(count), 32'd5);
        en = 1'b0;
        repeat (CNT_W + 4) cyc();
        see_digit(0, 7'h6D, "up5_d0");
        see_digit(1, LEAD, "up5_d1");
        see_digit(2, LEAD, "up5_d2");

        // Wrap in both directions
        pulse_load(999);
        check("load999", 32'(count), 32'd999);
        en = 1'b1; up = 1'b1;
        wait_count_change("wrap_up", 0);
        up = 1'b0;
        wait_count_change("wrap_dn", 999);
        en = 1'b0;
        repeat (CNT_W + 4) cyc();
        see_digit(0, 7'h6F, "nines_d0");
        see_digit(1, 7'h6F, "nines_d1");
        see_digit(2, 7'h6F, "nines_d2");

        // Load clip and load-over-tick priority
        pulse_load(1023);
        check("clip", 32'(count), 32'd999);
        en = 1'b1; up = 1'b1;
        for (int k = 0; k < TICK_DIV + 1 && m_pre != TICK_DIV - 1; k++) cyc();
        pulse_load(7);
        check("load_pri", 32'(count), 32'd7);
        repeat (TICK_DIV - 1) cyc();
        check("pre_clr_hold", 32'(count), 32'd7);
        cyc();
        check("pre_clr_tick", 32'(count), 32'd8);

        // Conversion latency: the old value stays on the display meanwhile
        en = 1'b0;
        repeat (CNT_W + 4) cyc();
        pulse_load(427);
        for (int k = 0; k < CNT_W + 1; k++) begin
            cyc();
            check("lat_hold", 32'(d7sp), 32'((m_tr == 1) ? seg_tab[8] : LEAD));
        end
        repeat (SCAN_DIV * DIGITS + 2) cyc();
        see_digit(0, 7'h07, "d427_0");
        see_digit(1, 7'h5B, "d427_1");
        see_digit(2, 7'h66, "d427_2");

        // Reset in the middle of a conversion
        en = 1'b1;
        pulse_load(300);
        repeat (3) cyc();
        rst = 1'b0;
        cyc();
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_tr", 32'(transistor), 32'b001);
        check("mid_rst_seg", 32'(d7sp), 32'h3F);
        rst = 1'b1; en = 1'b0;
        repeat (CNT_W + 4) cyc();
        see_digit(0, 7'h3F, "post_rst_d0");
        see_digit(1, LEAD, "post_rst_d1");

        // Randomised traffic against the model
        for (int n = 0; n < 1500; n++) begin
            en       = ($urandom_range(0, 9) != 0);
            up       = $urandom_range(0, 1) != 0;
            load     = ($urandom_range(0, 39) == 0);
            load_val = CNT_W'($urandom);
            rst      = ($urandom_range(0, 299) != 0);
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
